// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences a PLL through reset, lock acquisition and lock qualification,
// then holds the downstream logic in reset until lock has been stable for a
// programmable time. Failed lock attempts are retried a bounded number of
// times before a sticky failure state is entered; lock loss during normal
// operation restarts the whole sequence and is counted.
//
// Ports
//   sys_clk        in   1  reference clock (also feeds the PLL input)
//   sys_rst_n      in   1  synchronous active-low reset
//   pll_lock       in   1  PLL lock flag, asynchronous to sys_clk
//   pll_reset      out  1  active-high reset to the PLL (high in PLL_RST)
//   sys_rst_out_n  out  1  active-low reset for PLL-clocked logic (high in RUN)
//   locked_ok      out  1  high while in RUN
//   fail           out  1  sticky lock-failure flag (high in FAIL)
//   retry_cnt      out  2  retries used in the current lock sequence
//   lost_cnt       out  8  saturating count of lock losses seen in RUN
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 25000,
   parameter int LOCK_STABLE_CYCLES  = 2500,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       sys_rst_out_n,
   output logic       locked_ok,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [7:0] lost_cnt
);

   // One shared counter, wide enough for the longest of the three intervals.
   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
   localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    retry_next;
   logic [7:0]    lost_next;
   logic          sync1_reg, lock_s;

   // Next-state logic. retry_cnt and lost_cnt are updated alongside the
   // state so that they move on the same edge as the transition causing them.
   always_comb begin
      state_next = state_reg;
      retry_next = retry_cnt;
      lost_next  = lost_cnt;
      case (state_reg)
         ST_PLL_RST: begin
            if (cnt_reg == RST_LAST)
               state_next = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_next = ST_STABLE;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               if (retry_cnt == RETRY_LIMIT) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_PLL_RST;
                  retry_next = retry_cnt + 2'd1;
               end
            end
         end
         ST_STABLE: begin
            // A dropout restarts qualification with a fresh timeout but does
            // not consume a retry: the PLL did lock, just not cleanly yet.
            if (!lock_s)
               state_next = ST_WAIT_LOCK;
            else if (cnt_reg == STABLE_LAST)
               state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_next = ST_PLL_RST;
               retry_next = 2'd0;
               if (lost_cnt != 8'hFF)
                  lost_next = lost_cnt + 8'd1;
            end
         end
         ST_FAIL: begin
            state_next = ST_FAIL;
         end
         default: begin
            state_next = ST_PLL_RST;
         end
      endcase

      // Counter restarts on every state change so each state times itself
      // from zero; in RUN/FAIL it free-runs and its value is unused.
      if (state_next != state_reg)
         cnt_next = '0;
      else
         cnt_next = cnt_reg + CW'(1);
   end

   // State, counter, synchronizer and registered output decodes of the
   // next state, so every output changes on the same edge as the state.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_reg     <= ST_PLL_RST;
         cnt_reg       <= '0;
         sync1_reg     <= 1'b0;
         lock_s        <= 1'b0;
         pll_reset     <= 1'b1;
         sys_rst_out_n <= 1'b0;
         locked_ok     <= 1'b0;
         fail          <= 1'b0;
         retry_cnt     <= 2'd0;
         lost_cnt      <= 8'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         sync1_reg     <= pll_lock;
         lock_s        <= sync1_reg;
         pll_reset     <= (state_next == ST_PLL_RST);
         sys_rst_out_n <= (state_next == ST_RUN);
         locked_ok     <= (state_next == ST_RUN);
         fail          <= (state_next == ST_FAIL);
         retry_cnt     <= retry_next;
         lost_cnt      <= lost_next;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with short timing parameters
// (reset 4, timeout 32, stable 8, two retries). Inputs change and outputs are
// sampled 1 time unit after the rising edge.
module tb_pll_lock_supervisor;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       pll_lock;
   logic       pll_reset;
   logic       sys_rst_out_n;
   logic       locked_ok;
   logic       fail;
   logic [1:0] retry_cnt;
   logic [7:0] lost_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int n;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES     (4),
      .LOCK_TIMEOUT_CYCLES(32),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .pll_lock     (pll_lock),
      .pll_reset    (pll_reset),
      .sys_rst_out_n(sys_rst_out_n),
      .locked_ok    (locked_ok),
      .fail         (fail),
      .retry_cnt    (retry_cnt),
      .lost_cnt     (lost_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic step(input int cycles);
      repeat (cycles) @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps until pll_reset leaves the given level; bounded so a stuck DUT
   // produces a wrong count rather than a hang.
   task automatic run_len(input logic lvl, output int len);
      len = 0;
      while (pll_reset === lvl && len < 200) begin
         step(1);
         len++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".pll_reset"},     pll_reset,     1);
      chk({tag, ".sys_rst_out_n"}, sys_rst_out_n, 0);
      chk({tag, ".locked_ok"},     locked_ok,     0);
      chk({tag, ".fail"},          fail,          0);
      chk({tag, ".retry_cnt"},     retry_cnt,     0);
      chk({tag, ".lost_cnt"},      lost_cnt,      0);
   endtask

   // From RUN: drop lock, ride the 4-cycle PLL reset, relock in WAIT_LOCK.
   task automatic loss_relock();
      pll_lock = 1'b0;
      step(3);
      step(4);
      pll_lock = 1'b1;
      step(11);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      pll_lock  = 1'b0;

      // Reset state
      step(3);
      chk_reset_vals("reset");

      // Normal lock: 4-cycle PLL reset, RUN on 11th edge after lock rises
      sys_rst_n = 1'b1;
      run_len(1'b1, n);
      chk("norm.rst_len", n, 4);
      pll_lock = 1'b1;
      step(10);
      chk("norm.pre_run_rstn", sys_rst_out_n, 0);
      chk("norm.pre_run_ok", locked_ok, 0);
      step(1);
      chk("norm.run_rstn", sys_rst_out_n, 1);
      chk("norm.run_ok", locked_ok, 1);
      chk("norm.retry", retry_cnt, 0);
      chk("norm.pll_reset", pll_reset, 0);
      $display("txn normal_lock done: rstn=%0b ok=%0b retry=%0d", sys_rst_out_n, locked_ok, retry_cnt);

      // Loss in RUN: outputs drop on 3rd edge, 4-cycle reset, relock
      pll_lock = 1'b0;
      step(2);
      chk("loss.still_run", sys_rst_out_n, 1);
      step(1);
      chk("loss.rstn", sys_rst_out_n, 0);
      chk("loss.ok", locked_ok, 0);
      chk("loss.pll_reset", pll_reset, 1);
      chk("loss.lost", lost_cnt, 1);
      run_len(1'b1, n);
      chk("loss.rst_len", n, 4);
      pll_lock = 1'b1;
      step(10);
      chk("loss.pre_relock", sys_rst_out_n, 0);
      step(1);
      chk("loss.relock", sys_rst_out_n, 1);
      $display("txn loss_in_run done: lost=%0d rstn=%0b", lost_cnt, sys_rst_out_n);

      // Second loss, one timeout (retry_cnt -> 1), then glitch in STABLE
      pll_lock = 1'b0;
      step(3);
      chk("to.lost", lost_cnt, 2);
      run_len(1'b1, n);
      chk("to.rst_len", n, 4);
      run_len(1'b0, n);
      chk("to.wait_len", n, 32);
      chk("to.retry", retry_cnt, 1);
      run_len(1'b1, n);
      chk("to.rst_len2", n, 4);
      pll_lock = 1'b1;
      step(7);                  // STABLE with counter at 4 (5 stable cycles)
      pll_lock = 1'b0;
      step(3);
      chk("glitch.rstn_low", sys_rst_out_n, 0);
      pll_lock = 1'b1;
      step(10);
      chk("glitch.pre_run", sys_rst_out_n, 0);
      chk("glitch.no_pll_reset", pll_reset, 0);
      step(1);
      chk("glitch.run", sys_rst_out_n, 1);
      chk("glitch.retry", retry_cnt, 1);
      $display("txn stable_glitch done: rstn=%0b retry=%0d", sys_rst_out_n, retry_cnt);

      // Saturation: 300 loss/relock cycles starting from lost_cnt=2
      loss_relock();
      chk("sat.retry_cleared", retry_cnt, 0);
      chk("sat.lost3", lost_cnt, 3);
      for (int i = 1; i < 253; i++) loss_relock();
      chk("sat.lost255", lost_cnt, 255);
      for (int i = 0; i < 47; i++) loss_relock();
      chk("sat.held", lost_cnt, 255);
      chk("sat.run", locked_ok, 1);
      $display("txn saturation done: lost=%0d", lost_cnt);

      // Reset while in RUN
      sys_rst_n = 1'b0;
      step(1);
      chk_reset_vals("rst_run");
      $display("txn reset_in_run done: lost=%0d pll_reset=%0b", lost_cnt, pll_reset);

      // Never lock: three 4-cycle pulses separated by 32 low, then FAIL
      pll_lock  = 1'b0;
      sys_rst_n = 1'b1;
      run_len(1'b1, n);
      chk("nl.rst1", n, 4);
      run_len(1'b0, n);
      chk("nl.wait1", n, 32);
      chk("nl.retry1", retry_cnt, 1);
      run_len(1'b1, n);
      chk("nl.rst2", n, 4);
      run_len(1'b0, n);
      chk("nl.wait2", n, 32);
      chk("nl.retry2", retry_cnt, 2);
      run_len(1'b1, n);
      chk("nl.rst3", n, 4);
      step(31);
      chk("nl.pre_fail", fail, 0);
      step(1);
      chk("nl.fail", fail, 1);
      chk("nl.fail_pll_reset", pll_reset, 0);
      chk("nl.fail_rstn", sys_rst_out_n, 0);
      chk("nl.fail_retry", retry_cnt, 2);
      pll_lock = 1'b1;           // FAIL ignores lock
      step(50);
      chk("nl.sticky", fail, 1);
      chk("nl.sticky_pll_reset", pll_reset, 0);
      chk("nl.sticky_ok", locked_ok, 0);
      $display("txn never_lock done: fail=%0b retry=%0d", fail, retry_cnt);

      // Reset while in FAIL
      sys_rst_n = 1'b0;
      step(1);
      chk_reset_vals("rst_fail");
      $display("txn reset_in_fail done: fail=%0b pll_reset=%0b", fail, pll_reset);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles PLL reset is held per attempt, legal range 1 or more.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 25000: cycles to wait for lock per attempt (1 ms at 25 MHz), legal range 1 or more.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 2500: cycles lock must stay high before release (100 us), legal range 1 or more.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: retries after the first attempt before FAIL, legal range 0..3.
REQ-005 sys_clk  in  1  single clock, the 25 MHz reference also driving the PLL input.
REQ-006 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-007 pll_lock  in  1  PLL lock flag, asynchronous to sys_clk.
REQ-008 pll_reset  out  1  active-high reset to the PLL.
REQ-009 sys_rst_out_n  out  1  active-low synchronous reset for logic on the PLL output clock.
REQ-010 locked_ok  out  1  high while in RUN.
REQ-011 fail  out  1  sticky lock-failure flag.
REQ-012 retry_cnt  out  2  retries used in the current lock sequence.
REQ-013 lost_cnt  out  8  saturating count of lock losses seen in RUN.

Function
REQ-014 SHALL pass pll_lock through a 2-flop synchronizer; lock_s (2nd stage) is the only lock term used by the FSM.
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL, with one shared cycle counter sized to the largest count parameter.
REQ-016 SHALL clear the counter on every state change and increment it by 1 in every other cycle.
REQ-017 PLL_RST: when counter == PLL_RST_CYCLES-1, SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: lock_s=1 SHALL go to STABLE.
REQ-019 WAIT_LOCK, otherwise, at counter == LOCK_TIMEOUT_CYCLES-1: if retry_cnt == MAX_RETRIES SHALL go to FAIL; else SHALL increment retry_cnt and go to PLL_RST.
REQ-020 STABLE: lock_s=0 SHALL go to WAIT_LOCK with the full timeout restarted and retry_cnt unchanged.
REQ-021 STABLE, otherwise, at counter == LOCK_STABLE_CYCLES-1, SHALL go to RUN.
REQ-022 RUN: lock_s=0 SHALL go to PLL_RST, clear retry_cnt, and increment lost_cnt, saturating at 255.
REQ-023 FAIL SHALL be terminal until sys_rst_n=0, ignoring lock_s.
REQ-024 All outputs SHALL be registered decodes of the next state and change on the same edge as the state register.
REQ-025 pll_reset=1 iff the state is PLL_RST.
REQ-026 sys_rst_out_n=1 and locked_ok=1 iff the state is RUN.
REQ-027 fail=1 iff the state is FAIL.
REQ-028 In FAIL, pll_reset SHALL be 0 and sys_rst_out_n SHALL be 0.
REQ-029 With pll_lock held high from WAIT_LOCK, RUN SHALL be entered on the (LOCK_STABLE_CYCLES+3)th rising edge after pll_lock rises.
REQ-030 A lock_s low pulse of any length of at least 1 cycle in STABLE or RUN SHALL be acted on; no glitch filtering beyond the synchronizer.

Reset
REQ-031 While sys_rst_n=0 at a rising edge, SHALL set: state PLL_RST, counter 0, synchronizer flops 0, pll_reset=1, sys_rst_out_n=0, locked_ok=0, fail=0, retry_cnt=0, lost_cnt=0.
REQ-032 Reset SHALL take priority over every state transition, including mid-count and FAIL.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-033 Normal lock: release reset, raise pll_lock in WAIT_LOCK and hold -> pll_reset high exactly 4 cycles; sys_rst_out_n and locked_ok rise on the 11th edge after the pll_lock edge; retry_cnt=0.
REQ-034 Never lock: pll_lock held 0 -> exactly 3 pll_reset pulses of 4 cycles, each separated by 32 cycles low; then fail=1 with retry_cnt=2 and pll_reset=0, held indefinitely.
REQ-035 Glitch in STABLE: pll_lock low for 3 cycles after 5 stable cycles, then high -> sys_rst_out_n stays 0; release occurs 8 full stable cycles after lock_s returns; retry_cnt unchanged.
REQ-036 Loss in RUN: drop pll_lock -> sys_rst_out_n=0 and locked_ok=0 on the 3rd edge; 4-cycle pll_reset pulse; lost_cnt=1; relock proceeds as in REQ-033.
REQ-037 Saturation: 300 lock-loss/relock cycles -> lost_cnt stops at 255.
REQ-038 Reset mid-operation: assert sys_rst_n=0 in RUN, then separately in FAIL -> on the next edge all outputs equal the REQ-031 values.
